// File: rtl/decode_in_driver_fifo.sv
// decode_in transmit driver: an instruction FIFO feeding registered dout/npc_in/enable_decode.
// Optional feature macro: DECODE_IN_DRIVER_HOLD_EN (idle outputs hold the last issued word/PC).
module decode_in_driver_fifo #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h3000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [15:0]              push_instr,
  input  logic                     flush,
  input  logic [15:0]              flush_pc,
  input  logic                     stall,
  output logic                     enable_decode,
  output logic [15:0]              dout,
  output logic [15:0]              npc_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   pc;
  logic          do_push;
  logic          do_issue;
  logic [15:0]   head;

  // Full blocks a push even when a pop happens on the same edge.
  assign push_ready = reset && !flush && (count < FULL);
  assign do_push    = push_valid && push_ready;
  assign do_issue   = !flush && !stall && (count != '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= PC_RESET;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= flush_pc;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        pc     <= pc + 16'd1;
      end
      case ({do_push, do_issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_decode <= 1'b0;
      dout          <= 16'h0000;
      npc_in        <= 16'h0000;
    end else if (do_issue) begin
      enable_decode <= 1'b1;
      dout          <= head;
      npc_in        <= pc + 16'd1;
    end else begin
      enable_decode <= 1'b0;
`ifdef DECODE_IN_DRIVER_HOLD_EN
      dout          <= dout;
      npc_in        <= npc_in;
`else
      dout          <= 16'h0000;
      npc_in        <= 16'h0000;
`endif
    end
  end

endmodule

// File: tb/tb_decode_in_driver_fifo.sv
// Self-checking bench for decode_in_driver_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_decode_in_driver_fifo;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] PC_RESET = 16'h3000;
`ifdef DECODE_IN_DRIVER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] push_instr = 16'h0000;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q[$];
  logic [15:0] m_pc = PC_RESET;
  logic [15:0] m_dout = 16'h0000;
  logic [15:0] m_npc = 16'h0000;
  logic        m_en = 1'b0;

  decode_in_driver_fifo #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
    .push_instr(push_instr), .flush(flush), .flush_pc(flush_pc), .stall(stall),
    .enable_decode(enable_decode), .dout(dout), .npc_in(npc_in), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_pr;
    exp_pr = reset && !flush && (q.size() < DEPTH);
    chk({tag, ".en"},    32'(enable_decode), 32'(m_en));
    chk({tag, ".dout"},  32'(dout),          32'(m_dout));
    chk({tag, ".npc"},   32'(npc_in),        32'(m_npc));
    chk({tag, ".count"}, 32'(count),         32'(q.size()));
    chk({tag, ".ready"}, 32'(push_ready),    32'(exp_pr));
  endtask

  // One clock with the inputs currently driven; model advanced at the edge.
  task automatic cyc(input string tag);
    logic        pr;
    logic        take;
    logic [15:0] w;
    pr   = (q.size() < DEPTH) && !flush;
    take = push_valid && pr;
    w    = push_instr;
    @(posedge clock);
    if (flush) begin
      q.delete();
      m_pc = flush_pc;
      m_en = 1'b0;
      if (!HOLD) begin m_dout = 16'h0000; m_npc = 16'h0000; end
    end else begin
      if (!stall && q.size() > 0) begin
        m_en   = 1'b1;
        m_dout = q.pop_front();
        m_pc   = m_pc + 16'd1;
        m_npc  = m_pc;
      end else begin
        m_en = 1'b0;
        if (!HOLD) begin m_dout = 16'h0000; m_npc = 16'h0000; end
      end
      if (take) q.push_back(w);
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic pv, input logic [15:0] w, input logic st,
                       input logic fl, input logic [15:0] fpc);
    push_valid = pv; push_instr = w; stall = st; flush = fl; flush_pc = fpc;
  endtask

  task automatic push_word(input logic [15:0] w, input logic st, input string tag);
    drive(1'b1, w, st, 1'b0, 16'h0000);
    cyc(tag);
  endtask

  task automatic idle(input int n, input logic st, input string tag);
    drive(1'b0, 16'h0000, st, 1'b0, 16'h0000);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  // Asserts reset between edges and releases it after one full clock.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    q.delete();
    m_pc = PC_RESET; m_en = 1'b0; m_dout = 16'h0000; m_npc = 16'h0000;
    #1;
    check_all({tag, ".async"});
    @(posedge clock);
    #1;
    check_all({tag, ".held"});
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    // reset state
    #1;
    q.delete();
    check_all("por");
    @(posedge clock); #1;
    check_all("por_hold");
    reset = 1'b1;
    #1;
    check_all("por_rel");

    // stream of three words
    push_word(16'h1234, 1'b0, "s2_p0");
    push_word(16'h5678, 1'b0, "s2_p1");
    chk("s2_first_npc", 32'(npc_in), 32'h3001);
    push_word(16'h9ABC, 1'b0, "s2_p2");
    idle(1, 1'b0, "s2_i");
    chk("s2_last_dout", 32'(dout), 32'h9ABC);
    chk("s2_last_npc", 32'(npc_in), 32'h3003);
    idle(2, 1'b0, "s2_idle");
    chk("s6_idle_dout", 32'(dout), HOLD ? 32'h9ABC : 32'h0000);

    // back-pressure: fill under stall
    for (int i = 0; i < DEPTH; i++) push_word(16'hA000 + 16'(i), 1'b1, "s3_fill");
    chk("s3_full_count", 32'(count), 32'd4);
    chk("s3_full_ready", 32'(push_ready), 32'd0);
    push_word(16'hDEAD, 1'b1, "s3_blocked");
    push_word(16'hBEEF, 1'b0, "s3_full_pop");
    idle(DEPTH + 1, 1'b0, "s3_drain");
    chk("s3_ready_after", 32'(push_ready), 32'd1);

    // reset mid-issue
    for (int i = 0; i < 3; i++) push_word(16'hC000 + 16'(i), 1'b0, "s1_run");
    chk("s1_issuing", 32'(enable_decode), 32'd1);
    do_reset("s1_rst");
    push_word(16'h7777, 1'b0, "s1_p");
    idle(1, 1'b0, "s1_i");
    chk("s1_npc_after_rst", 32'(npc_in), 32'h3001);
    idle(1, 1'b0, "s1_i2");

    // flush with queued words and a same-cycle push
    for (int i = 0; i < 3; i++) push_word(16'hF000 + 16'(i), 1'b1, "s4_fill");
    drive(1'b1, 16'hEEEE, 1'b1, 1'b1, 16'h4000);
    cyc("s4_flush");
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("s4_count0", 32'(count), 32'd0);
    push_word(16'h1111, 1'b0, "s4_p");
    idle(1, 1'b0, "s4_i");
    chk("s4_npc", 32'(npc_in), 32'h4001);
    chk("s4_dout", 32'(dout), 32'h1111);

    // pc wrap
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFE);
    cyc("s5_flush");
    push_word(16'h2222, 1'b0, "s5_p0");
    push_word(16'h3333, 1'b0, "s5_p1");
    chk("s5_npc_ffff", 32'(npc_in), 32'hFFFF);
    idle(1, 1'b0, "s5_i");
    chk("s5_npc_0000", 32'(npc_in), 32'h0000);
    idle(1, 1'b0, "s5_i2");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rnd_rst");
      drive(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 99) < 3), 16'($urandom));
      cyc("rnd");
    end
    idle(DEPTH + 1, 1'b0, "rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
